// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, fixed
// addresses and next-PC unit select encodings.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Next-PC unit: sequential, PC-relative branch and J-type jump targets
// computed from a single base PC.
module fetch_ctrl_npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  sel,
    input  logic [31:0] br_off32,
    input  logic [25:0] jmp_idx26,
    output logic [31:0] npc
);

    logic [31:0] seq_tgt;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;

    // Word offset to byte offset; the shift drops bits 31:30 of the offset.
    assign seq_tgt = pc + 32'd4;
    assign br_tgt  = pc + (br_off32 << 2);
    assign jmp_tgt = {pc[31:28], jmp_idx26, 2'b00};

    always_comb begin
        npc = seq_tgt;
        case (sel)
            NPC_SEQ: npc = seq_tgt;
            NPC_BR:  npc = br_tgt;
            NPC_J:   npc = jmp_tgt;
            default: npc = seq_tgt;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding request FSM that holds one
// fetched instruction for decode and redirects on branch/jump/flush.
module fetch_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_off32,
    input  logic        jmp,
    input  logic [25:0] jmp_idx26,
    input  logic        jr,
    input  logic [31:0] jr_tgt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic         if_valid_reg;
    logic [31:0]  if_ins_reg;
    logic [31:0]  if_pc_reg;

    logic [1:0]   npc_sel;
    logic [31:0]  npc_out;
    logic [31:0]  next_pc;
    logic         req_pending;

    assign npc_sel = jmp ? NPC_J : (br_taken ? NPC_BR : NPC_SEQ);

    fetch_ctrl_npc u_npc (
        .pc        (if_pc_reg),
        .sel       (npc_sel),
        .br_off32  (br_off32),
        .jmp_idx26 (jmp_idx26),
        .npc       (npc_out)
    );

    assign next_pc = jr ? (jr_tgt & ~32'h3) : npc_out;

    // A request is still owed a response unless it completes this very cycle.
    assign req_pending = ((state_reg == ST_WAIT || state_reg == ST_DRAIN) && !imem_rvalid)
                       || (state_reg == ST_FETCH && imem_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            if_valid_reg <= 1'b0;
            if_ins_reg   <= 32'h0;
            if_pc_reg    <= 32'h0;
        end else if (flush) begin
            pc_reg       <= EXC_VEC;
            if_valid_reg <= 1'b0;
            state_reg    <= req_pending ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_gnt)
                        state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if_ins_reg   <= imem_rdata;
                        if_pc_reg    <= pc_reg;
                        if_valid_reg <= 1'b1;
                        state_reg    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_reg       <= next_pc;
                        if_valid_reg <= 1'b0;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid)
                        state_reg <= ST_FETCH;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign if_valid  = if_valid_reg;
    assign if_ins    = if_ins_reg;
    assign if_pc     = if_pc_reg;

endmodule
